// File: rtl/torture_chk_pkg.sv
// Shared types for the commit-trace checker: golden record layout, FSM
// encoding and the bit positions of the failure mask.
package torture_chk_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] inst;
    logic [63:0] dst;
    logic        wr_valid;
    logic [63:0] data;
    logic        xcpt;
    logic [63:0] cause;
    logic        last;
  } commit_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2,
    ST_DONE = 2'd3
  } chk_state_e;

  localparam int MASK_W         = 7;
  localparam int MASK_PC        = 0;
  localparam int MASK_INST      = 1;
  localparam int MASK_DST       = 2;
  localparam int MASK_WR_VALID  = 3;
  localparam int MASK_DATA      = 4;
  localparam int MASK_XCPT      = 5;
  localparam int MASK_UNDERFLOW = 6;

endpackage

// File: rtl/torture_trace_checker_if.sv
// Golden-record stream and writeback commit port of the trace checker.
// The master side is the host/core, the slave side is the checker.
interface torture_trace_checker_if;

  logic        exp_valid;
  logic        exp_ready;
  logic [63:0] exp_pc;
  logic [63:0] exp_inst;
  logic [63:0] exp_reg_dst;
  logic        exp_reg_wr_valid;
  logic [63:0] exp_data;
  logic        exp_xcpt;
  logic [63:0] exp_xcpt_cause;
  logic        exp_last;

  logic        commit_valid;
  logic [63:0] pc;
  logic [63:0] inst;
  logic [63:0] reg_dst;
  logic        reg_wr_valid;
  logic [63:0] data;
  logic        xcpt;
  logic [63:0] xcpt_cause;

  modport master (
    output exp_valid, exp_pc, exp_inst, exp_reg_dst, exp_reg_wr_valid,
           exp_data, exp_xcpt, exp_xcpt_cause, exp_last,
           commit_valid, pc, inst, reg_dst, reg_wr_valid, data, xcpt, xcpt_cause,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_pc, exp_inst, exp_reg_dst, exp_reg_wr_valid,
           exp_data, exp_xcpt, exp_xcpt_cause, exp_last,
           commit_valid, pc, inst, reg_dst, reg_wr_valid, data, xcpt, xcpt_cause,
    output exp_ready
  );

endinterface

// File: rtl/torture_chk_fifo.sv
// Synchronous FIFO of golden commit records. Pointers carry an extra wrap
// bit so full and empty are distinguished without a separate counter.
module torture_chk_fifo
  import torture_chk_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  commit_rec_t wdata,
  input  logic        pop,
  output commit_rec_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  commit_rec_t mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; overflow and underflow requests are dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset alone empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/torture_trace_checker.sv
// Commit-trace checker: buffers golden records and compares each committed
// instruction against the FIFO head, latching the first divergence.
module torture_trace_checker
  import torture_chk_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PC_BITS    = 40,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  torture_trace_checker_if.slave bus,
  output logic [1:0]           chk_state,
  output logic                 mismatch,
  output logic [MASK_W-1:0]    mismatch_mask,
  output logic [CNT_W-1:0]     mismatch_index,
  output logic [CNT_W-1:0]     commit_count,
  output logic                 done
);

  localparam logic [63:0]      PC_MASK = (PC_BITS >= 64) ? {64{1'b1}} : ((64'd1 << PC_BITS) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  chk_state_e          state_q, state_d;
  logic                mismatch_q, mismatch_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    index_q, index_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                done_q, done_d;
  logic                ready_en_q;

  commit_rec_t         wdata_s, head_s;
  logic                full_s, empty_s, busy_s, push_s, pop_s, commit_fire_s;
  logic [MASK_W-1:0]   cmp_mask_s, fail_mask_s;

  assign busy_s        = (state_q == ST_IDLE) || (state_q == ST_RUN);
  // ready_en_q keeps exp_ready low while in reset and the cycle it releases.
  assign bus.exp_ready = ready_en_q && (busy_s ? !full_s : 1'b1);
  assign push_s        = bus.exp_valid && bus.exp_ready && busy_s;
  assign commit_fire_s = (state_q == ST_RUN) && bus.commit_valid;
  assign pop_s         = commit_fire_s && !empty_s;

  assign wdata_s = '{pc: bus.exp_pc, inst: bus.exp_inst, dst: bus.exp_reg_dst,
                     wr_valid: bus.exp_reg_wr_valid, data: bus.exp_data,
                     xcpt: bus.exp_xcpt, cause: bus.exp_xcpt_cause, last: bus.exp_last};

  torture_chk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (wdata_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Field compare of the FIFO head against the commit; don't-care fields follow the expected record.
  always_comb begin
    cmp_mask_s = '0;
    cmp_mask_s[MASK_PC]        = ((head_s.pc ^ bus.pc) & PC_MASK) != 64'd0;
    cmp_mask_s[MASK_INST]      = head_s.inst != bus.inst;
    cmp_mask_s[MASK_DST]       = head_s.wr_valid && (head_s.dst != bus.reg_dst);
    cmp_mask_s[MASK_WR_VALID]  = head_s.wr_valid != bus.reg_wr_valid;
    cmp_mask_s[MASK_DATA]      = head_s.wr_valid && (head_s.dst != 64'd0) && (head_s.data != bus.data);
    cmp_mask_s[MASK_XCPT]      = (head_s.xcpt != bus.xcpt) || (head_s.xcpt && (head_s.cause != bus.xcpt_cause));
    cmp_mask_s[MASK_UNDERFLOW] = 1'b0;
    if (empty_s) begin
      fail_mask_s = 7'b1000000;
    end else begin
      fail_mask_s = cmp_mask_s;
    end
  end

  // FSM next state plus the sticky result and counter updates.
  always_comb begin
    state_d    = state_q;
    mismatch_d = mismatch_q;
    mask_d     = mask_q;
    index_d    = index_q;
    done_d     = done_q;
    if (commit_fire_s && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (commit_fire_s && (fail_mask_s != 7'd0)) begin
          state_d    = ST_FAIL;
          mismatch_d = 1'b1;
          mask_d     = fail_mask_s;
          index_d    = count_q;
        end else if (commit_fire_s && head_s.last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mismatch_q <= 1'b0;
      mask_q     <= '0;
      index_q    <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      mask_q     <= mask_d;
      index_q    <= index_d;
      count_q    <= count_d;
      done_q     <= done_d;
      ready_en_q <= 1'b1;
    end
  end

  assign chk_state      = state_q;
  assign mismatch       = mismatch_q;
  assign mismatch_mask  = mask_q;
  assign mismatch_index = index_q;
  assign commit_count   = count_q;
  assign done           = done_q;

endmodule

// File: tb/tb_torture_trace_checker.sv
// Self-checking bench for torture_trace_checker: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_torture_trace_checker;

  localparam int DEPTH = 16;
  localparam int PCB   = 40;
  localparam int CW    = 32;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] inst;
    logic [63:0] dst;
    logic        wr;
    logic [63:0] data;
    logic        xcpt;
    logic [63:0] cause;
    logic        last;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    chk_state;
  logic          mismatch;
  logic [6:0]    mismatch_mask;
  logic [CW-1:0] mismatch_index;
  logic [CW-1:0] commit_count;
  logic          done;

  int checks = 0;
  int errors = 0;

  torture_trace_checker_if bus();

  torture_trace_checker #(.FIFO_DEPTH(DEPTH), .PC_BITS(PCB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .chk_state(chk_state), .mismatch(mismatch), .mismatch_mask(mismatch_mask),
    .mismatch_index(mismatch_index), .commit_count(commit_count), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model state
  int            m_state;
  rec_t          m_q[$];
  logic          m_mismatch, m_done, m_rdy_en;
  logic [6:0]    m_mask;
  logic [CW-1:0] m_index, m_count;

  function automatic logic m_ready();
    if (!m_rdy_en) return 1'b0;
    if (m_state >= 2) return 1'b1;
    return (m_q.size() < DEPTH);
  endfunction

  function automatic logic [6:0] ref_mask(rec_t e, rec_t c);
    logic [6:0]  m   = 7'd0;
    logic [63:0] pcm = (64'd1 << PCB) - 64'd1;
    if (((e.pc ^ c.pc) & pcm) != 64'd0) m[0] = 1'b1;
    if (e.inst != c.inst) m[1] = 1'b1;
    if (e.wr && e.dst != c.dst) m[2] = 1'b1;
    if (e.wr != c.wr) m[3] = 1'b1;
    if (e.wr && e.dst != 64'd0 && e.data != c.data) m[4] = 1'b1;
    if (e.xcpt != c.xcpt || (e.xcpt && e.cause != c.cause)) m[5] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_q.delete(); m_mismatch = 1'b0; m_done = 1'b0; m_rdy_en = 1'b0;
    m_mask = 7'd0; m_index = '0; m_count = '0;
  endtask

  // Apply one clock edge worth of behaviour using the inputs currently driven.
  task automatic model_step();
    rec_t e, c;
    logic [6:0] fm;
    logic do_push = bus.exp_valid && m_ready() && (m_state <= 1);
    logic fire = (m_state == 1) && bus.commit_valid;
    int nxt = m_state;
    e = '{pc: bus.exp_pc, inst: bus.exp_inst, dst: bus.exp_reg_dst, wr: bus.exp_reg_wr_valid,
          data: bus.exp_data, xcpt: bus.exp_xcpt, cause: bus.exp_xcpt_cause, last: bus.exp_last};
    c = '{pc: bus.pc, inst: bus.inst, dst: bus.reg_dst, wr: bus.reg_wr_valid,
          data: bus.data, xcpt: bus.xcpt, cause: bus.xcpt_cause, last: 1'b0};
    if (m_state == 0) begin
      if (enable) nxt = 1;
    end else if (m_state == 1) begin
      if (fire) begin
        rec_t h;
        if (m_q.size() == 0) begin
          fm = 7'b1000000;
          h.last = 1'b0;
        end else begin
          h = m_q.pop_front();
          fm = ref_mask(h, c);
        end
        if (fm != 7'd0) begin
          nxt = 2; m_mismatch = 1'b1; m_mask = fm; m_index = m_count;
        end else if (h.last) begin
          nxt = 3; m_done = 1'b1;
        end else if (!enable) begin
          nxt = 0;
        end
        if (m_count != {CW{1'b1}}) m_count = m_count + 1;
      end else if (!enable) begin
        nxt = 0;
      end
    end
    if (do_push) m_q.push_back(e);
    m_state  = nxt;
    m_rdy_en = 1'b1;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.pc    = {$urandom, $urandom};
    r.inst  = {$urandom, $urandom};
    r.dst   = 64'($urandom_range(0, 3));
    r.wr    = 1'($urandom_range(0, 1));
    r.data  = {$urandom, $urandom};
    r.xcpt  = ($urandom_range(0, 3) == 0);
    r.cause = 64'($urandom_range(0, 15));
    r.last  = 1'b0;
    return r;
  endfunction

  task automatic set_exp(rec_t r);
    bus.exp_pc = r.pc; bus.exp_inst = r.inst; bus.exp_reg_dst = r.dst; bus.exp_reg_wr_valid = r.wr;
    bus.exp_data = r.data; bus.exp_xcpt = r.xcpt; bus.exp_xcpt_cause = r.cause; bus.exp_last = r.last;
  endtask

  task automatic set_commit(rec_t r);
    bus.pc = r.pc; bus.inst = r.inst; bus.reg_dst = r.dst; bus.reg_wr_valid = r.wr;
    bus.data = r.data; bus.xcpt = r.xcpt; bus.xcpt_cause = r.cause;
  endtask

  task automatic drive_idle();
    rec_t z = '{pc: 64'd0, inst: 64'd0, dst: 64'd0, wr: 1'b0, data: 64'd0, xcpt: 1'b0, cause: 64'd0, last: 1'b0};
    set_exp(z); set_commit(z);
    bus.exp_valid = 1'b0; bus.commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle(); enable = 1'b0; rst = 1'b1; model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic push_rec(rec_t r);
    set_exp(r); bus.exp_valid = 1'b1; tick(); bus.exp_valid = 1'b0;
  endtask

  task automatic commit_rec(rec_t r);
    set_commit(r); bus.commit_valid = 1'b1; tick(); bus.commit_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle(); rst = 1'b1; model_reset();
    #2;
    checks++;
    if ({chk_state, mismatch, mismatch_mask, mismatch_index, commit_count, done, bus.exp_ready} !== '0) begin
      errors++; $display("FAIL reset_outputs got state=%0d mm=%0b mask=%b idx=%0d cnt=%0d done=%0b rdy=%0b exp all 0",
        chk_state, mismatch, mismatch_mask, mismatch_index, commit_count, done, bus.exp_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready got %0b exp 0", bus.exp_ready); end
    tick();
    checks++;
    if (bus.exp_ready !== 1'b1 || chk_state !== 2'd0) begin
      errors++; $display("FAIL post_reset got rdy=%0b state=%0d exp rdy=1 state=0", bus.exp_ready, chk_state);
    end
  endtask

  task automatic test_basic_done();
    rec_t r[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin r[i] = rand_rec(); r[i].last = (i == 2); push_rec(r[i]); end
    enable = 1'b1; tick();
    commit_rec(r[0]); commit_rec(r[1]);
    checks++;
    if (done !== 1'b0 || commit_count !== 32'd2) begin
      errors++; $display("FAIL basic_mid got done=%0b cnt=%0d exp done=0 cnt=2", done, commit_count);
    end
    commit_rec(r[2]);
    checks++;
    if (done !== 1'b1 || chk_state !== 2'd3 || commit_count !== 32'd3 || mismatch !== 1'b0) begin
      errors++; $display("FAIL basic_done got done=%0b state=%0d cnt=%0d mm=%0b exp 1 3 3 0", done, chk_state, commit_count, mismatch);
    end
  endtask

  task automatic test_data_mismatch();
    rec_t r[3];
    rec_t c;
    do_reset();
    for (int i = 0; i < 3; i++) r[i] = rand_rec();
    r[1].wr = 1'b1; r[1].dst = 64'd5; r[1].data = 64'h55; r[1].xcpt = 1'b0;
    for (int i = 0; i < 3; i++) push_rec(r[i]);
    enable = 1'b1; tick();
    commit_rec(r[0]);
    c = r[1]; c.data = 64'h56;
    commit_rec(c);
    checks++;
    if (mismatch !== 1'b1 || mismatch_mask !== 7'b0010000 || mismatch_index !== 32'd1 || chk_state !== 2'd2) begin
      errors++; $display("FAIL data_mismatch got mm=%0b mask=%b idx=%0d state=%0d exp 1 0010000 1 2",
        mismatch, mismatch_mask, mismatch_index, chk_state);
    end
    commit_rec(r[2]); commit_rec(rand_rec());
    checks++;
    if (commit_count !== 32'd2 || mismatch_mask !== 7'b0010000) begin
      errors++; $display("FAIL fail_sticky got cnt=%0d mask=%b exp 2 0010000", commit_count, mismatch_mask);
    end
  endtask

  task automatic test_dont_care();
    rec_t r[2];
    rec_t c;
    do_reset();
    r[0] = rand_rec(); r[0].wr = 1'b1; r[0].dst = 64'd0;
    r[1] = rand_rec(); r[1].last = 1'b1;
    push_rec(r[0]); push_rec(r[1]);
    enable = 1'b1; tick();
    c = r[0]; c.data = ~r[0].data; commit_rec(c);
    c = r[1]; c.pc = r[1].pc ^ (64'd1 << 45); commit_rec(c);
    checks++;
    if (mismatch !== 1'b0 || done !== 1'b1 || chk_state !== 2'd3 || commit_count !== 32'd2) begin
      errors++; $display("FAIL dont_care got mm=%0b done=%0b state=%0d cnt=%0d exp 0 1 3 2", mismatch, done, chk_state, commit_count);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    enable = 1'b1; tick();
    set_exp(rand_rec()); bus.exp_valid = 1'b1;
    set_commit(rand_rec()); bus.commit_valid = 1'b1;
    tick();
    drive_idle();
    checks++;
    if (mismatch_mask !== 7'b1000000 || mismatch_index !== 32'd0 || mismatch !== 1'b1 || chk_state !== 2'd2) begin
      errors++; $display("FAIL underflow got mask=%b idx=%0d mm=%0b state=%0d exp 1000000 0 1 2",
        mismatch_mask, mismatch_index, mismatch, chk_state);
    end
  endtask

  task automatic test_full();
    rec_t r[DEPTH];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin r[i] = rand_rec(); push_rec(r[i]); end
    checks++;
    if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", bus.exp_ready); end
    enable = 1'b1; tick();
    set_exp(rand_rec()); bus.exp_valid = 1'b1;
    commit_rec(r[0]);
    checks++;
    if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got %0b exp 1", bus.exp_ready); end
    tick();
    bus.exp_valid = 1'b0;
    checks++;
    if (bus.exp_ready !== 1'b0 || commit_count !== 32'd1 || mismatch !== 1'b0) begin
      errors++; $display("FAIL refill got rdy=%0b cnt=%0d mm=%0b exp 0 1 0", bus.exp_ready, commit_count, mismatch);
    end
  endtask

  task automatic test_reset_mid_run();
    rec_t r[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin r[i] = rand_rec(); push_rec(r[i]); end
    enable = 1'b1; tick();
    commit_rec(r[0]);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({chk_state, mismatch, mismatch_mask, mismatch_index, commit_count, done, bus.exp_ready} !== '0) begin
      errors++; $display("FAIL midrun_reset got state=%0d cnt=%0d rdy=%0b exp all 0", chk_state, commit_count, bus.exp_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (bus.exp_ready !== 1'b1 || chk_state !== 2'd1) begin
      errors++; $display("FAIL midrun_release got rdy=%0b state=%0d exp 1 1", bus.exp_ready, chk_state);
    end
    commit_rec(r[1]);
    checks++;
    if (mismatch_mask !== 7'b1000000) begin
      errors++; $display("FAIL midrun_fifo_empty got mask=%b exp 1000000", mismatch_mask);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rec_t e, c;
      enable = ($urandom_range(0, 9) != 0);
      e = rand_rec(); e.last = ($urandom_range(0, 29) == 0);
      set_exp(e); bus.exp_valid = 1'($urandom_range(0, 1));
      if (m_q.size() > 0) begin
        c = m_q[0];
        if ($urandom_range(0, 19) == 0) begin
          case ($urandom_range(0, 6))
            0: c.pc = c.pc ^ (64'd1 << $urandom_range(0, 63));
            1: c.inst = c.inst ^ 64'd1;
            2: c.dst = c.dst + 64'd1;
            3: c.wr = ~c.wr;
            4: c.data = c.data ^ 64'd1;
            5: c.xcpt = ~c.xcpt;
            default: c.cause = c.cause + 64'd1;
          endcase
        end
      end else begin
        c = rand_rec();
      end
      set_commit(c); bus.commit_valid = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (chk_state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state got %0d exp %0d", chk_state, m_state); end
      checks++;
      if (mismatch !== m_mismatch || mismatch_mask !== m_mask) begin
        errors++; $display("FAIL rnd_mismatch got %0b/%b exp %0b/%b", mismatch, mismatch_mask, m_mismatch, m_mask);
      end
      checks++;
      if (mismatch_index !== m_index) begin errors++; $display("FAIL rnd_index got %0d exp %0d", mismatch_index, m_index); end
      checks++;
      if (commit_count !== m_count) begin errors++; $display("FAIL rnd_count got %0d exp %0d", commit_count, m_count); end
      checks++;
      if (done !== m_done) begin errors++; $display("FAIL rnd_done got %0b exp %0b", done, m_done); end
      checks++;
      if (bus.exp_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready got %0b exp %0b", bus.exp_ready, m_ready()); end
      if (m_state >= 2 && $urandom_range(0, 7) == 0) do_reset();
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_basic_done();
    test_data_mismatch();
    test_dont_care();
    test_underflow();
    test_full();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
